// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode values,
// sequencer state encoding and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] OP_NOOP    = 4'd0;
    localparam logic [3:0] OP_RESET   = 4'd1;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_AND     = 4'd5;
    localparam logic [3:0] OP_ADD     = 4'd6;
    localparam logic [3:0] OP_SUB     = 4'd8;
    localparam logic [3:0] OP_EQUAL   = 4'd12;
    localparam logic [3:0] OP_GREATER = 4'd13;
    localparam logic [3:0] OP_LESS    = 4'd14;
    localparam logic [3:0] OP_ERROR   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Classifies a 4-bit ALU opcode into the handling classes used by the
// sequencer. Exactly one flag is high for every opcode value.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_logic_arith,
    output logic       is_compare,
    output logic       is_reset,
    output logic       is_noop,
    output logic       is_illegal
);

    // Opcode class lookup; anything not listed is treated as illegal.
    always_comb begin
        is_logic_arith = 1'b0;
        is_compare     = 1'b0;
        is_reset       = 1'b0;
        is_noop        = 1'b0;
        is_illegal     = 1'b0;
        case (opcode)
            OP_NOOP:                        is_noop        = 1'b1;
            OP_RESET:                       is_reset       = 1'b1;
            OP_OR, OP_AND, OP_ADD, OP_SUB:  is_logic_arith = 1'b1;
            OP_EQUAL, OP_GREATER, OP_LESS:  is_compare     = 1'b1;
            default:                        is_illegal     = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side controller for the 32-bit ALU. Accepts one command at a
// time, issues it with the accumulator as operand A, waits a fixed number
// of edges for the ALU, writes back and returns a response.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH       = ALU_WIDTH,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error,
    output logic [WIDTH-1:0] acc
);

    localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY);

    seq_state_e       state_r;
    seq_state_e       state_next_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [3:0]       alu_opcode_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_error_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] operand_r;
    logic             wb_acc_r;
    logic [3:0]       cnt_r;
    logic             cmd_ready_s;
    logic             accept_s;
    logic             is_logic_arith_s;
    logic             is_compare_s;
    logic             is_reset_s;
    logic             is_noop_s;
    logic             is_illegal_s;

    alu_op_decode u_decode (
        .opcode         (cmd_opcode),
        .is_logic_arith (is_logic_arith_s),
        .is_compare     (is_compare_s),
        .is_reset       (is_reset_s),
        .is_noop        (is_noop_s),
        .is_illegal     (is_illegal_s)
    );

    // Ready only in IDLE, and forced low while reset is asserted.
    assign cmd_ready_s = (state_r == ST_IDLE) && reset;
    assign accept_s    = cmd_valid && cmd_ready_s;

    assign cmd_ready  = cmd_ready_s;
    assign rsp_valid  = (state_r == ST_RESP);
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_opcode_r;
    assign rsp_result = rsp_result_r;
    assign rsp_error  = rsp_error_r;
    assign acc        = acc_r;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: ALU ops go through ISSUE/WAIT, the rest answer at once.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_logic_arith_s || is_compare_s) begin
                        state_next_s = ST_ISSUE;
                    end else begin
                        state_next_s = ST_RESP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: command capture, ALU drive, latency count and writeback.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_r        <= '0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_opcode_r <= OP_NOOP;
            rsp_result_r <= '0;
            rsp_error_r  <= 1'b0;
            op_r         <= OP_NOOP;
            operand_r    <= '0;
            wb_acc_r     <= 1'b0;
            cnt_r        <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r      <= cmd_opcode;
                        operand_r <= cmd_operand;
                        wb_acc_r  <= is_logic_arith_s;
                        if (is_reset_s) begin
                            acc_r        <= '0;
                            rsp_result_r <= '0;
                            rsp_error_r  <= 1'b0;
                        end else if (is_noop_s) begin
                            rsp_result_r <= acc_r;
                            rsp_error_r  <= 1'b0;
                        end else if (is_illegal_s) begin
                            rsp_result_r <= acc_r;
                            rsp_error_r  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    alu_a_r      <= acc_r;
                    alu_b_r      <= operand_r;
                    alu_opcode_r <= op_r;
                    cnt_r        <= LAT_INIT;
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd1) begin
                        cnt_r <= 4'd0;
                        // Compares return only bit 0 and leave the accumulator alone.
                        if (wb_acc_r) begin
                            acc_r        <= alu_result;
                            rsp_result_r <= alu_result;
                        end else begin
                            rsp_result_r <= {{(WIDTH-1){1'b0}}, alu_result[0]};
                        end
                        rsp_error_r <= alu_error;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        alu_opcode_r <= OP_NOOP;
                    end
                end
                default: begin
                    alu_opcode_r <= OP_NOOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer. A command-level reference model
// predicts each response; a monitor pops and compares on every handshake.
// A second instance with a 4-edge pipelined ALU covers latency and reset
// during WAIT.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural ALU used as the environment: {error, result}.
    function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (op)
            4'd3:    return {1'b0, a | b};
            4'd5:    return {1'b0, a & b};
            4'd6:    begin s = {1'b0, a} + {1'b0, b}; return s; end
            4'd8:    return {(b > a), a - b};
            4'd12:   return {1'b0, 31'd0, (a == b)};
            4'd13:   return {1'b0, 31'd0, (a > b)};
            4'd14:   return {1'b0, 31'd0, (a < b)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // ---------------- DUT A: ALU_LATENCY = 1 ----------------
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = 4'd0;
    logic [31:0] cmd_operand = 32'd0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_error;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic [31:0] acc;

    assign {alu_error, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

    alu_op_sequencer #(.WIDTH(32), .ALU_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .acc(acc)
    );

    // ---------------- DUT B: ALU_LATENCY = 4, pipelined ALU ----------------
    logic        b_reset = 1'b0;
    logic        b_cmd_valid = 1'b0;
    logic        b_cmd_ready;
    logic [3:0]  b_cmd_opcode = 4'd0;
    logic [31:0] b_cmd_operand = 32'd0;
    logic [31:0] b_alu_a, b_alu_b, b_alu_result;
    logic [3:0]  b_alu_opcode;
    logic        b_alu_error;
    logic        b_rsp_valid;
    logic        b_rsp_ready = 1'b1;
    logic [31:0] b_rsp_result;
    logic        b_rsp_error;
    logic [31:0] b_acc;
    logic [32:0] b_pipe [3];

    // Three register stages: the result is only correct 4 edges after issue.
    always @(posedge clk) begin
        b_pipe[0] <= alu_f(b_alu_opcode, b_alu_a, b_alu_b);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign {b_alu_error, b_alu_result} = b_pipe[2];

    alu_op_sequencer #(.WIDTH(32), .ALU_LATENCY(4)) dut_b (
        .clk(clk), .reset(b_reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_opcode(b_cmd_opcode), .cmd_operand(b_cmd_operand),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_opcode(b_alu_opcode),
        .alu_result(b_alu_result), .alu_error(b_alu_error),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_result(b_rsp_result), .rsp_error(b_rsp_error), .acc(b_acc)
    );

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [31:0] acc;
        int          delta;
        int          acc_cyc;
        bit          no_issue;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_acc = 32'd0;
    bit          hold_ready = 1'b0;

    // Command-level semantics: what the response and accumulator must be.
    task automatic model_step(input logic [3:0] op, input logic [31:0] b, output exp_t e);
        logic [63:0] wide;
        e.err = 1'b0; e.delta = 2; e.no_issue = 1'b0; e.acc_cyc = 0;
        case (op)
            4'd0:  begin e.res = model_acc; e.delta = 0; e.no_issue = 1'b1; end
            4'd1:  begin model_acc = 32'd0; e.res = 32'd0; e.delta = 0; e.no_issue = 1'b1; end
            4'd3:  begin model_acc = model_acc | b; e.res = model_acc; end
            4'd5:  begin model_acc = model_acc & b; e.res = model_acc; end
            4'd6:  begin wide = 64'(model_acc) + 64'(b); e.err = (wide >= 64'h1_0000_0000);
                         model_acc = wide[31:0]; e.res = model_acc; end
            4'd8:  begin e.err = (b > model_acc); model_acc = model_acc - b; e.res = model_acc; end
            4'd12: e.res = (model_acc == b) ? 32'd1 : 32'd0;
            4'd13: e.res = (model_acc > b)  ? 32'd1 : 32'd0;
            4'd14: e.res = (model_acc < b)  ? 32'd1 : 32'd0;
            default: begin e.res = model_acc; e.err = 1'b1; e.delta = 0; e.no_issue = 1'b1; end
        endcase
        e.acc = model_acc;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] b);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        cmd_opcode = op; cmd_operand = b; cmd_valid = 1'b1;
        model_step(op, b, e);
        e.acc_cyc = cyc + 1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        q.push_back(e);
    endtask

    // Response consumer: random backpressure unless a test holds it low.
    initial begin
        forever begin
            @(posedge clk);
            #1 rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stability under stall and scoreboard compare on handshake.
    int          rise_cyc = 0;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = 32'd0;
    logic        prev_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            if (prev_stall && rsp_valid) begin
                chk("stall_result_stable", rsp_result, prev_res);
                chk("stall_error_stable", 32'(rsp_error), 32'(prev_err));
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_response: got 0x%08h expected none", rsp_result);
                end else begin
                    e = q.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_error", 32'(rsp_error), 32'(e.err));
                    chk("acc", acc, e.acc);
                    chk("latency", 32'(rise_cyc - e.acc_cyc), 32'(e.delta));
                    if (e.no_issue) chk("alu_opcode_noop", 32'(alu_opcode), 32'd0);
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_valid = rsp_valid;
            prev_res   = rsp_result;
            prev_err   = rsp_error;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          n;
        logic [3:0]  op;
        logic [31:0] b;
        int          t_acc;

        // Reset state of DUT A.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_acc", acc, 32'd0);
        chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Add chain.
        send(4'd6, 32'd65535);
        send(4'd6, 32'd2);
        // Subtract wrap.
        send(4'd1, 32'd0);
        send(4'd6, 32'd10);
        send(4'd8, 32'd30);
        // Compares with acc = 5.
        send(4'd1, 32'd0);
        send(4'd6, 32'd5);
        send(4'd13, 32'd3);
        send(4'd12, 32'd3);
        send(4'd14, 32'd9);
        // Illegal opcode with acc = 7.
        send(4'd1, 32'd0);
        send(4'd6, 32'd7);
        send(4'd2, 32'd0);
        send(4'd0, 32'd0);

        // Backpressure: response held for 5 cycles, extra commands ignored.
        send(4'd1, 32'd0);
        send(4'd6, 32'h0001_FFFF);
        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        hold_ready = 1'b1;
        send(4'd5, 32'h0000_FFFF);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        cmd_opcode = 4'd6; cmd_operand = 32'd1;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2 == 0);
            @(negedge clk);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_result", rsp_result, 32'h0000_FFFF);
            chk("bp_acc", acc, 32'h0000_FFFF);
        end
        cmd_valid = 1'b0;
        hold_ready = 1'b0;

        // Randomized command stream.
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            send(op, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        n = 0;
        while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        // DUT B: latency 4 with a pipelined ALU.
        b_reset = 1'b1;
        @(negedge clk);
        b_cmd_opcode = 4'd6; b_cmd_operand = 32'd100; b_cmd_valid = 1'b1;
        chk("b_cmd_ready", 32'(b_cmd_ready), 32'd1);
        t_acc = cyc + 1;
        @(posedge clk);
        #1 b_cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_rsp_valid && n < 30) begin @(negedge clk); n++; end
        chk("b_latency", 32'(cyc - t_acc), 32'd5);
        chk("b_rsp_result", b_rsp_result, 32'd100);
        chk("b_acc", b_acc, 32'd100);
        @(negedge clk);

        // Reset during WAIT.
        b_cmd_opcode = 4'd6; b_cmd_operand = 32'd23; b_cmd_valid = 1'b1;
        @(posedge clk);
        #1 b_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        b_reset = 1'b0;
        #1 chk("b_reset_cmd_ready_low", 32'(b_cmd_ready), 32'd0);
        @(posedge clk);
        #1 b_reset = 1'b1;
        @(negedge clk);
        chk("b_reset_rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("b_reset_acc", b_acc, 32'd0);
        chk("b_reset_alu_opcode", 32'(b_alu_opcode), 32'd0);
        chk("b_reset_cmd_ready", 32'(b_cmd_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("b_dropped_rsp", 32'(b_rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
